// File: rtl/fir_da_pkg.sv
// Shared constants, state encoding and Gray helper for the DA FIR LUT loader.
package fir_da_pkg;

  localparam int unsigned TAPS   = 64;
  localparam int unsigned GSIZE  = 8;
  localparam int unsigned GROUPS = 8;
  localparam int unsigned CW     = 16;
  localparam int unsigned LW     = 20;
  localparam int unsigned AW     = 11;

  // Derived widths: group index, flip-bit index, coefficient counter.
  localparam int unsigned KW   = $clog2(GROUPS);
  localparam int unsigned BW   = $clog2(GSIZE);
  localparam int unsigned CNTW = $clog2(TAPS);

  typedef enum logic [1:0] {COLLECT, BUILD, RUN} state_t;

  function automatic logic [GSIZE-1:0] gray8(input logic [GSIZE-1:0] g);
    return g ^ (g >> 1);
  endfunction

endpackage

// File: rtl/da_step_sel.sv
// Gray-walk step selector: which tap bit flips at step g, and in which direction.
module da_step_sel
  import fir_da_pkg::*;
(
  input  logic [GSIZE-1:0] g,
  output logic [BW-1:0]    b,
  output logic             add
);

  logic [GSIZE:0] gx;
  logic [BW:0]    hi;

  // Trailing-zero count of g; the flipped Gray bit is g[b]^g[b+1] with g[b]=1,
  // so it turns on (add) exactly when g[b+1] is 0.
  always_comb begin
    b = '0;
    for (int unsigned i = 0; i < GSIZE; i++) begin
      if (g[GSIZE-1-i]) b = BW'(GSIZE-1-i);
    end
    gx  = {1'b0, g};
    hi  = {1'b0, b} + (BW+1)'(1);
    add = ~gx[hi];
  end

endmodule

// File: rtl/da_lut_loader.sv
// Collects 64 coefficients and builds the 2048-entry DA partial-sum LUT,
// one Gray-ordered entry per clock, then flags the LUT as valid.
module da_lut_loader
  import fir_da_pkg::*;
(
  input  logic          clk_fast,
  input  logic          reset,
  input  logic [CW-1:0] coef_in,
  input  logic          coef_valid,
  output logic          coef_ready,
  input  logic          reload,
  output logic [LW-1:0] CIN,
  output logic [AW-1:0] CADDR,
  output logic          CLOAD,
  output logic          busy,
  output logic          lut_valid
);

  state_t          state;
  logic [CNTW-1:0] cnt;
  logic [AW-1:0]   n;
  logic [CW-1:0]   coef [TAPS];

  logic [AW-1:0]    n_nxt;
  logic [GSIZE-1:0] g_nxt;
  logic [KW-1:0]    k_nxt;
  logic [BW-1:0]    b_sel;
  logic             add_sel;
  logic [CW-1:0]    c_sel;
  logic [LW-1:0]    c_ext;
  logic [LW-1:0]    acc_nxt;

  da_step_sel u_step (
    .g   (g_nxt),
    .b   (b_sel),
    .add (add_sel)
  );

  // Next BUILD entry: CIN holds the running sum, so each step is one add/sub.
  always_comb begin
    n_nxt   = n + AW'(1);
    g_nxt   = n_nxt[GSIZE-1:0];
    k_nxt   = n_nxt[AW-1:GSIZE];
    c_sel   = coef[{k_nxt, b_sel}];
    c_ext   = {{(LW-CW){c_sel[CW-1]}}, c_sel};
    acc_nxt = '0;
    if (g_nxt != '0) begin
      acc_nxt = add_sel ? (CIN + c_ext) : (CIN - c_ext);
    end
  end

  // Coefficient store, written on each accepted handshake.
  always_ff @(posedge clk_fast) begin
    if (!reset && state == COLLECT && coef_valid && coef_ready) begin
      coef[cnt] <= coef_in;
    end
  end

  // Control FSM with registered outputs; registers always show write n.
  always_ff @(posedge clk_fast) begin
    if (reset) begin
      state      <= COLLECT;
      cnt        <= '0;
      n          <= '0;
      coef_ready <= 1'b1;
      CLOAD      <= 1'b0;
      busy       <= 1'b0;
      lut_valid  <= 1'b0;
      CIN        <= '0;
      CADDR      <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (coef_valid && coef_ready) begin
            cnt <= cnt + CNTW'(1);
            if (cnt == CNTW'(TAPS-1)) begin
              // Entry 0 of group 0 is issued directly on the last handshake.
              state      <= BUILD;
              n          <= '0;
              coef_ready <= 1'b0;
              CLOAD      <= 1'b1;
              busy       <= 1'b1;
              CIN        <= '0;
              CADDR      <= '0;
            end
          end
        end
        BUILD: begin
          if (n == '1) begin
            state     <= RUN;
            CLOAD     <= 1'b0;
            busy      <= 1'b0;
            lut_valid <= 1'b1;
          end else begin
            n     <= n_nxt;
            CIN   <= acc_nxt;
            CADDR <= {k_nxt, gray8(g_nxt)};
          end
        end
        RUN: begin
          if (reload) begin
            state      <= COLLECT;
            cnt        <= '0;
            lut_valid  <= 1'b0;
            coef_ready <= 1'b1;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_da_lut_loader.sv
// Directed bench for da_lut_loader: LUT contents, write order and control timing.
module tb_da_lut_loader;

  logic        clk;
  logic        reset;
  logic [15:0] coef_in;
  logic        coef_valid;
  logic        coef_ready;
  logic        reload;
  logic [19:0] CIN;
  logic [10:0] CADDR;
  logic        CLOAD;
  logic        busy;
  logic        lut_valid;

  da_lut_loader dut (
    .clk_fast   (clk),
    .reset      (reset),
    .coef_in    (coef_in),
    .coef_valid (coef_valid),
    .coef_ready (coef_ready),
    .reload     (reload),
    .CIN        (CIN),
    .CADDR      (CADDR),
    .CLOAD      (CLOAD),
    .busy       (busy),
    .lut_valid  (lut_valid)
  );

  int tests;
  int fails;

  logic signed [15:0] mc [64];

  // Write capture, cleared on request
  logic        clr;
  int          cyc;
  int          wr_total;
  int          first_cload;
  int          valid_rise;
  logic        prev_valid;
  int          wr_count [2048];
  logic [19:0] lut_mem  [2048];
  logic [10:0] seq_addr [2048];
  logic [19:0] seq_cin  [2048];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc = 0;
    prev_valid = 1'b0;
  end

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (clr) begin
      wr_total    = 0;
      first_cload = -1;
      valid_rise  = -1;
      for (int a = 0; a < 2048; a++) begin
        wr_count[a] = 0;
        lut_mem[a]  = '0;
        seq_addr[a] = '0;
        seq_cin[a]  = '0;
      end
    end else begin
      if (CLOAD === 1'b1) begin
        if (wr_total == 0) first_cload = cyc;
        if (wr_total < 2048) begin
          seq_addr[wr_total] = CADDR;
          seq_cin[wr_total]  = CIN;
        end
        wr_count[CADDR] = wr_count[CADDR] + 1;
        lut_mem[CADDR]  = CIN;
        wr_total = wr_total + 1;
      end
      if (lut_valid === 1'b1 && prev_valid !== 1'b1 && valid_rise < 0) valid_rise = cyc;
    end
    prev_valid = lut_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_coefs(input bit gaps);
    clr = 1'b1;
    @(negedge clk); #1;
    clr = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 64; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 3)) begin
          coef_valid = 1'b0;
          coef_in    = 16'($urandom);
          @(posedge clk); #1;
        end
      end
      coef_valid = 1'b1;
      coef_in    = mc[i];
      @(posedge clk); #1;
    end
    coef_valid = 1'b0;
    check("first_cload", 32'(CLOAD), 32'd1);
    check("first_caddr", 32'(CADDR), 32'd0);
    check("first_cin", 32'(CIN), 32'd0);
    check("first_busy", 32'(busy), 32'd1);
    check("build_not_ready", 32'(coef_ready), 32'd0);
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 2200 && lut_valid !== 1'b1; i++) @(negedge clk);
    #1;
    check({tag, "_valid_timeout"}, 32'(lut_valid), 32'd1);
  endtask

  task automatic check_lut(input string tag);
    int bad_val;
    int bad_cnt;
    int s;
    logic [19:0] e;
    bad_val = 0;
    bad_cnt = 0;
    for (int a = 0; a < 2048; a++) begin
      s = 0;
      for (int b = 0; b < 8; b++) begin
        if (a[b]) s = s + int'(mc[(a >> 8) * 8 + b]);
      end
      e = s[19:0];
      if (lut_mem[a] !== e) bad_val++;
      if (wr_count[a] != 1) bad_cnt++;
    end
    check({tag, "_lut_entries_bad"}, 32'(bad_val), 32'd0);
    check({tag, "_addr_not_once"}, 32'(bad_cnt), 32'd0);
    check({tag, "_write_total"}, 32'(wr_total), 32'd2048);
  endtask

  task automatic do_reload();
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
    check("reload_lut_valid", 32'(lut_valid), 32'd0);
    check("reload_coef_ready", 32'(coef_ready), 32'd1);
  endtask

  initial begin
    tests      = 0;
    fails      = 0;
    reset      = 1'b1;
    coef_in    = '0;
    coef_valid = 1'b0;
    reload     = 1'b0;
    clr        = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_coef_ready", 32'(coef_ready), 32'd1);
    check("rst_cload", 32'(CLOAD), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_lut_valid", 32'(lut_valid), 32'd0);
    check("rst_cin", 32'(CIN), 32'd0);
    check("rst_caddr", 32'(CADDR), 32'd0);
    reset = 1'b0;
    clr   = 1'b0;
    @(posedge clk); #1;
    check("collect_ready", 32'(coef_ready), 32'd1);

    // All coefficients 1: entries are popcounts, order and group reset
    for (int i = 0; i < 64; i++) mc[i] = 16'sd1;
    load_coefs(1'b0);
    wait_valid("ones");
    check_lut("ones");
    check("ones_cin_0ff", 32'(lut_mem[11'h0FF]), 32'd8);
    check("order_n0", 32'(seq_addr[0]), 32'h000);
    check("order_n1", 32'(seq_addr[1]), 32'h001);
    check("order_n2", 32'(seq_addr[2]), 32'h003);
    check("order_n3", 32'(seq_addr[3]), 32'h002);
    check("order_n4", 32'(seq_addr[4]), 32'h006);
    check("order_n256_addr", 32'(seq_addr[256]), 32'h100);
    check("order_n256_cin", 32'(seq_cin[256]), 32'h0);
    check("order_last_addr", 32'(seq_addr[2047]), 32'h780);
    check("ones_valid_latency", 32'(valid_rise - first_cload), 32'd2048);
    check("run_cload", 32'(CLOAD), 32'd0);
    check("run_busy", 32'(busy), 32'd0);
    check("run_not_ready", 32'(coef_ready), 32'd0);

    // All coefficients -32768: most negative sums
    do_reload();
    for (int i = 0; i < 64; i++) mc[i] = -16'sd32768;
    load_coefs(1'b0);
    wait_valid("neg");
    check_lut("neg");
    check("neg_cin_7ff", 32'(lut_mem[11'h7FF]), 32'h000C0000);
    check("neg_cin_001", 32'(lut_mem[11'h001]), 32'h000F8000);

    // Random coefficients with gaps; reload and coef_valid ignored during BUILD
    do_reload();
    for (int i = 0; i < 64; i++) mc[i] = 16'($urandom);
    load_coefs(1'b1);
    repeat (100) @(posedge clk);
    #1;
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
    check("reload_build_ignored", 32'(busy), 32'd1);
    coef_valid = 1'b1;
    repeat (200) begin
      coef_in = 16'($urandom);
      @(posedge clk); #1;
    end
    coef_valid = 1'b0;
    wait_valid("rand");
    check_lut("rand");
    check("rand_valid_latency", 32'(valid_rise - first_cload), 32'd2048);

    // Reset at n=1000, then a fresh full load
    do_reload();
    for (int i = 0; i < 64; i++) mc[i] = 16'($urandom);
    load_coefs(1'b0);
    for (int i = 0; i < 1200 && wr_total != 1001; i++) begin
      @(negedge clk); #1;
    end
    check("reach_n1000", 32'(wr_total), 32'd1001);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst_cload", 32'(CLOAD), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_coef_ready", 32'(coef_ready), 32'd1);
    check("midrst_lut_valid", 32'(lut_valid), 32'd0);
    for (int i = 0; i < 64; i++) mc[i] = 16'($urandom);
    load_coefs(1'b0);
    wait_valid("after_rst");
    check_lut("after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/da_lut_loader.md
# da_lut_loader

Configuration controller for the 64-tap distributed-arithmetic FIR filter. It accepts 64 signed 16-bit coefficients over a ready/valid stream and computes the filter's 2048-entry partial-sum LUT (8 groups × 256 entries) in hardware, one entry per clock. It drives the filter's `CIN`/`CADDR`/`CLOAD` write port, then releases the datapath through `lut_valid`. This replaces host-side LUT precomputation.

## Interface
- `TAPS`, 64, number of filter taps (must equal `GROUPS*GSIZE`).
- `GSIZE`, 8, taps per DA group (LUT entries per group = 2^GSIZE).
- `GROUPS`, 8, number of DA groups.
- `CW`, 16, coefficient width (signed).
- `LW`, 20, LUT word width (signed); must be ≥ `CW + log2(GSIZE)`.
- `AW`, 11, LUT address width, `log2(GROUPS) + GSIZE`.

- `clk_fast` in 1, the single clock; all state changes on its rising edge.
- `reset` in 1, synchronous, active-high.
- `coef_in` in `CW`, signed coefficient, tap order 0..63.
- `coef_valid` in 1, coefficient offered.
- `coef_ready` out 1, coefficient accepted when `coef_valid && coef_ready`.
- `reload` in 1, single-cycle request to replace the coefficients.
- `CIN` out `LW`, LUT write data.
- `CADDR` out `AW`, LUT write address.
- `CLOAD` out 1, LUT write strobe, one write per cycle while high.
- `busy` out 1, high in BUILD.
- `lut_valid` out 1, LUT complete; drives the filter's `valid_in`.

## Operation
- **States:**
  - COLLECT (reset state): `coef_ready=1`. Each handshake writes `coef_in` to `coef[cnt]` and increments the 6-bit `cnt`. The handshake with `cnt==63` moves the FSM to BUILD with `n=0` and `acc=0`.
  - BUILD: 2048 cycles, `n`=0..2047. `coef_ready=0`. After `n==2047` the FSM moves to RUN.
  - RUN: `lut_valid=1`. A `reload` pulse moves the FSM to COLLECT with `cnt=0`, and `lut_valid` drops.
- **BUILD sequencing:**
  - Group `k=n[10:8]`, step `g=n[7:0]`, Gray address `gr=g^(g>>1)`.
  - The entry for `gr` is the sum of `coef[8k+b]` over the bits `b` set in `gr`.
  - Traversal is Gray order, so one add or subtract per entry. At `g==0`, `acc=0`. Otherwise `b` = trailing-zero count of `g`: add `coef[8k+b]` if `gr[b]==1`, else subtract it.
  - Write issued for step `n`: `CADDR={k, gr}`, `CIN=acc`, `CLOAD=1`.
- **Arithmetic:** coefficients are sign-extended to `LW`. Worst case `8×(−32768) = −262144` fits in 20-bit signed, so no saturation logic is required.
- **Ignored inputs:**
  - `coef_valid` outside COLLECT.
  - `reload` in COLLECT or BUILD.
- **Reset** (at any time, including mid-BUILD): the FSM returns to COLLECT with `cnt=0` and `n=0`. The partially written LUT is not trusted; a full 64-coefficient load is required.

## Timing
- **Reset values:**
  - `coef_ready=1` (COLLECT)
  - `CLOAD=0`, `busy=0`, `lut_valid=0`
  - `CIN=0`, `CADDR=0`
- All outputs are registered.
- **Write latency:**
  - The first write (`CADDR=0`, `CIN=0`) appears the cycle after the 64th handshake.
  - `CLOAD` is high for exactly 2048 consecutive cycles.
  - `busy` is coincident with `CLOAD`.
  - `lut_valid` rises the cycle after the last write (`CADDR={3'd7, 8'h80}`).
- **Full-load timing:** 64 coefficients at 1/cycle give 64 + 2048 cycles from the first handshake to the `lut_valid` rise.
- **Coefficient stream:** gaps in `coef_valid` stall COLLECT without limit.
- **`reload` in RUN:** `lut_valid=0` and `coef_ready=1` on the next cycle.

## Structure
- **Shared package `fir_da_pkg`:**
  - Constants `TAPS`, `GSIZE`, `GROUPS`, `CW`, `LW`, `AW`.
  - State enum `{COLLECT, BUILD, RUN}`.
  - Function `gray8(g)`.
- **Sub-module `da_step_sel`** (combinational): from `g`, outputs the flip-bit index `b` and the add/subtract flag.
- The coefficient store is a 64×`CW` register array inside `da_lut_loader`.

## Test plan
- **All coefficients = 1:** every `CIN` equals `popcount(CADDR[7:0])`. `CADDR=0x0FF` gives `CIN=8`. Exactly 2048 writes, and each address is written exactly once.
- **Write order:** `n`=0..4 give `CADDR` 0, 1, 3, 2, 6. At `n=256`, `CADDR=0x100` and `CIN=0` (accumulator reset at the group boundary).
- **All coefficients = −32768:** `CADDR=0x7FF` gives `CIN=20'hC0000`. `CADDR=0x001` gives `CIN=20'hF8000`.
- **Random coefficients, valid with random gaps:** the full LUT matches the software model `sum(coef[8k+b] for set bits)`, and `lut_valid` rises 2048 cycles after the first `CLOAD`.
- **`reset` asserted at `n=1000`:**
  - Next cycle: `CLOAD=0`, `busy=0`, `coef_ready=1`.
  - A reloaded coefficient set produces a correct complete LUT.
- **Ignored and honored `reload`:**
  - `reload` during BUILD is ignored (the write count stays 2048).
  - `reload` in RUN drops `lut_valid` the next cycle, and a new set rebuilds correctly.
